seq_alu_booth: RTL and testbench

//   Parametrised sequential ALU with a start/busy/done handshake.
//   - Single-cycle ops: copy, complement, AND, OR, XOR, add, subtract.
//   - Multi-cycle op: signed radix-2 Booth multiply.

---
 rtl/seq_alu_booth.sv | 188 ++++++++++++++++++
 tb/tb_seq_alu_booth.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_booth.sv
// seq_alu_booth: sequential ALU with single-cycle logic/arith ops and a radix-2 Booth multiply.
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags output.
module seq_alu_booth #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         sel,
  input  logic [WIDTH-1:0]   r1,
  input  logic [WIDTH-1:0]   r2,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]         flags
`endif
);
  localparam int         RW     = 2*WIDTH;
  localparam int         CW     = $clog2(WIDTH+1);
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {IDLE, MUL} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [RW-1:0]           result_q, result_d;
  logic                    done_q, done_d;
  logic signed [WIDTH:0]   acc_q, acc_d;
  logic signed [WIDTH:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]        mq_q, mq_d;
  logic                    q1_q, q1_d;
  logic [2*WIDTH+1:0]      step;
  logic [RW-1:0]           op_res;
  logic [RW-1:0]           mul_res;
`ifdef ALU_FLAGS_EN
  logic [3:0]              flags_q, flags_d;
`endif

  function automatic logic [RW-1:0] single_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] dif;
    logic [RW-1:0]    r;
    sum = {1'b0, a} + {1'b0, b};
    dif = a - b;
    r   = '0;
    case (op)
      3'd0:    r[WIDTH-1:0] = a;
      3'd1:    r[WIDTH-1:0] = ~a;
      3'd2:    r[WIDTH-1:0] = a & b;
      3'd3:    r[WIDTH-1:0] = a | b;
      3'd4:    r[WIDTH-1:0] = a ^ b;
      3'd5:    r[WIDTH:0]   = sum;
      3'd6:    r            = {{WIDTH{dif[WIDTH-1]}}, dif};
      default: r            = '0;
    endcase
    return r;
  endfunction

  // One Booth step: conditional add/sub of M into A, then arithmetic shift of {A,Q,Q_1}.
  function automatic logic [2*WIDTH+1:0] booth_step(input logic signed [WIDTH:0] a,
                                                   input logic signed [WIDTH:0] m,
                                                   input logic [WIDTH-1:0]      q,
                                                   input logic                  q1);
    logic signed [WIDTH:0] s;
    case ({q[0], q1})
      2'b01:   s = a + m;
      2'b10:   s = a - m;
      default: s = a;
    endcase
    return {s[WIDTH], s, q};
  endfunction

`ifdef ALU_FLAGS_EN
  function automatic logic [3:0] op_flags(input logic [2:0]       op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [RW-1:0]    r);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] dif;
    logic             c;
    logic             v;
    sum = {1'b0, a} + {1'b0, b};
    dif = a - b;
    c   = 1'b0;
    v   = 1'b0;
    if (op == 3'd5) begin
      c = sum[WIDTH];
      v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (op == 3'd6) begin
      c = (a >= b);
      v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    end
    return {r[RW-1], (r == '0), c, v};
  endfunction
`endif

  assign step    = booth_step(acc_q, mcand_q, mq_q, q1_q);
  assign op_res  = single_op(sel, r1, r2);
  assign mul_res = step[2*WIDTH:1];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mq_d     = mq_q;
    q1_d     = q1_q;
`ifdef ALU_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel == OP_MUL) begin
            state_d = MUL;
            acc_d   = '0;
            mcand_d = {r1[WIDTH-1], r1};
            mq_d    = r2;
            q1_d    = 1'b0;
            count_d = '0;
          end else begin
            result_d = op_res;
            done_d   = 1'b1;
`ifdef ALU_FLAGS_EN
            flags_d  = op_flags(sel, r1, r2, op_res);
`endif
          end
        end
      end
      MUL: begin
        {acc_d, mq_d, q1_d} = step;
        if (count_q != CW'(WIDTH)) count_d = count_q + 1'b1;
        // start is deliberately not looked at here: an in-flight multiply is never disturbed.
        if (count_q == CW'(WIDTH-1)) begin
          state_d  = IDLE;
          result_d = mul_res;
          done_d   = 1'b1;
`ifdef ALU_FLAGS_EN
          flags_d  = op_flags(OP_MUL, '0, '0, mul_res);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef ALU_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  // Booth datapath registers: only meaningful while in MUL, so no reset.
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    mq_q    <= mq_d;
    q1_q    <= q1_d;
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == MUL);
`ifdef ALU_FLAGS_EN
  assign flags  = flags_q;
`endif

endmodule

// File: tb/tb_seq_alu_booth.sv
// Self-checking bench for seq_alu_booth: cycle model plus directed vectors with literal expectations.
module tb_seq_alu_booth;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2:0]     sel;
  logic [W-1:0]   r1, r2;
  logic [2*W-1:0] result;
  logic           done, busy;
  logic           start16;
  logic [2:0]     sel16;
  logic [15:0]    a16, b16;
  logic [31:0]    result16;
  logic           done16, busy16;
`ifdef ALU_FLAGS_EN
  logic [3:0]     flags, flags16;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_alu_booth #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .r1(r1), .r2(r2),
    .result(result), .done(done), .busy(busy)
`ifdef ALU_FLAGS_EN
    , .flags(flags)
`endif
  );

  seq_alu_booth #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sel(sel16), .r1(a16), .r2(b16),
    .result(result16), .done(done16), .busy(busy16)
`ifdef ALU_FLAGS_EN
    , .flags(flags16)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [2*W-1:0] ref_op(input logic [2:0] s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0]        z;
    logic [W-1:0]          d;
    logic signed [2*W-1:0] p;
    z = '0;
    case (s)
      3'd0: z[W-1:0] = a;
      3'd1: z[W-1:0] = ~a;
      3'd2: z[W-1:0] = a & b;
      3'd3: z[W-1:0] = a | b;
      3'd4: z[W-1:0] = a ^ b;
      3'd5: z = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      3'd6: begin d = a - b; z = {{W{d[W-1]}}, d}; end
      default: begin p = $signed(a) * $signed(b); z = p; end
    endcase
    return z;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [2:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [2*W-1:0] res);
    int ua, ub, sa, sb, rs;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0;
    if (s == 3'd5) begin
      rs = sa + sb;
      c = (ua + ub) > (2**W - 1);
      v = (rs > 2**(W-1) - 1) || (rs < -(2**(W-1)));
    end else if (s == 3'd6) begin
      rs = sa - sb;
      c = (ua >= ub);
      v = (rs > 2**(W-1) - 1) || (rs < -(2**(W-1)));
    end
    return {res[2*W-1], res == '0, c, v};
  endfunction

  logic [2*W-1:0] m_result, m_prod;
  logic           m_done;
  logic [3:0]     m_flags;
  int             m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result = '0; m_done = 1'b0; m_flags = '0; m_cnt = 0; m_prod = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_result = m_prod;
          m_flags  = ref_flags(3'd7, '0, '0, m_prod);
          m_done   = 1'b1;
        end
      end else if (start) begin
        if (sel == 3'd7) begin
          m_cnt  = W;
          m_prod = ref_op(sel, r1, r2);
        end else begin
          m_result = ref_op(sel, r1, r2);
          m_flags  = ref_flags(sel, r1, r2, m_result);
          m_done   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model result", result, m_result);
      chk("model done", done, m_done);
      chk("model busy", busy, m_cnt > 0);
`ifdef ALU_FLAGS_EN
      chk("model flags", flags, m_flags);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; sel = s; r1 = a; r2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (!done && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int npulse;
    rst_n = 1'b0; start = 1'b0; sel = '0; r1 = '0; r2 = '0;
    start16 = 1'b0; sel16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset result", result, 16'h0000);
    chk("reset done", done, 1'b0);
    chk("reset busy", busy, 1'b0);

    issue(3'd5, 8'hFF, 8'h01);
    chk("add result", result, 16'h0100);
    chk("add done", done, 1'b1);
`ifdef ALU_FLAGS_EN
    chk("add flags", flags, 4'b0010);
`endif
    @(negedge clk);
    chk("done one cycle", done, 1'b0);

    issue(3'd6, 8'h05, 8'h07);
    chk("sub neg", result, 16'hFFFE);
`ifdef ALU_FLAGS_EN
    chk("sub neg flags", flags, 4'b1000);
`endif
    issue(3'd6, 8'h80, 8'h01);
    chk("sub ovf", result, 16'h007F);
`ifdef ALU_FLAGS_EN
    chk("sub ovf flags", flags, 4'b0011);
`endif
    issue(3'd0, 8'hA5, 8'h00);
    chk("copy", result, 16'h00A5);
    issue(3'd1, 8'hA5, 8'h00);
    chk("complement", result, 16'h005A);

    issue(3'd7, 8'hFD, 8'h05);
    chk("mul busy", busy, 1'b1);
    wait_done(20, cyc);
    chk("mul latency", cyc, 8);
    chk("mul FD*05", result, 16'hFFF1);
    issue(3'd7, 8'h80, 8'h80);
    wait_done(20, cyc);
    chk("mul 80*80", result, 16'h4000);

    issue(3'd7, 8'h13, 8'hF6);
    @(negedge clk);
    start = 1'b1; sel = 3'd5; r1 = 8'h01; r2 = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, cyc);
    chk("mul ignore start", result, 16'hFF42);

    issue(3'd7, 8'hFD, 8'h05);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort result", result, 16'h0000);
    chk("abort done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("no done after abort", npulse, 0);

    @(negedge clk);
    start = 1'b1; sel = 3'd2; r1 = 8'hF0; r2 = 8'h3C;
    @(negedge clk);
    chk("b2b and", result, 16'h0030);
    chk("b2b done1", done, 1'b1);
    sel = 3'd3;
    @(negedge clk);
    chk("b2b or", result, 16'h00FC);
    chk("b2b done2", done, 1'b1);
    sel = 3'd4;
    @(negedge clk);
    chk("b2b xor", result, 16'h00CC);
    chk("b2b done3", done, 1'b1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b done end", done, 1'b0);

    @(negedge clk);
    start16 = 1'b1; sel16 = 3'd7; a16 = 16'h7FFF; b16 = 16'h7FFF;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("mul16 latency", cyc, 16);
    chk("mul16 result", result16, 32'h3FFF0001);
`ifdef ALU_FLAGS_EN
    chk("mul16 flags", flags16, 4'b0000);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
